cascade_mod_counter: RTL

CASCADE_MOD_COUNTER -- requirements
Module: cascade_mod_counter

---
 rtl/clock_pkg.sv | 13 +
 rtl/cascade_mod_counter_if.sv | 28 ++
 rtl/mod_counter_stage.sv | 49 ++++
 rtl/cascade_mod_counter.sv | 104 ++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared digit-counter constants: default terminal-count profiles for cascaded
// counters (seconds/minutes chain, BCD decade) and the default digit width.
package clock_pkg;

    localparam int unsigned DIGIT_W = 4;

    // Stage 0 is the least significant field: sec units, sec tens, min units, ...
    localparam logic [23:0] TC_MIN_SEC_CHAIN = {4'd5, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};

    localparam logic [3:0]  TC_BCD_DECADE    = 4'd9;
    localparam logic [23:0] TC_BCD_6DIGIT    = {6{TC_BCD_DECADE}};

endpackage

// File: rtl/cascade_mod_counter_if.sv
// Control/data bundle of the cascaded modulo counter; the slave side is the counter.
interface cascade_mod_counter_if
    import clock_pkg::*;
#(
    parameter int unsigned WIDTH  = DIGIT_W,
    parameter int unsigned NSTAGE = 6
);
    logic                      en;
    logic                      up;
    logic                      clr;
    logic                      load;
    logic [NSTAGE*WIDTH-1:0]   load_data;
    logic [NSTAGE*WIDTH-1:0]   q;
    logic [NSTAGE-1:0]         tc;
    logic                      carry_out;
    logic                      load_err;

    modport master (
        output en, up, clr, load, load_data,
        input  q, tc, carry_out, load_err
    );

    modport slave (
        input  en, up, clr, load, load_data,
        output q, tc, carry_out, load_err
    );

endinterface

// File: rtl/mod_counter_stage.sv
// One up/down modulo-(TC+1) digit. Priority clr > load > step; tc reflects the
// wrap condition for the current direction.
module mod_counter_stage #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TC    = '1
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             step,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = value;
        end else if (step) begin
            if (up) begin
                q_d = (q_q == TC) ? '0 : q_q + WIDTH'(1);
            end else begin
                q_d = (q_q == '0) ? TC : q_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    always_comb begin
        q  = q_q;
        tc = up ? (q_q == TC) : (q_q == '0);
    end

endmodule

// File: rtl/cascade_mod_counter.sv
// NSTAGE cascaded modulo digits with ripple-free enable gating: every stage
// updates on the same edge, gated by the tc flags of all lower stages.
module cascade_mod_counter
    import clock_pkg::*;
#(
    parameter int unsigned WIDTH  = DIGIT_W,
    parameter int unsigned NSTAGE = 6,
    parameter              TC_VEC = TC_MIN_SEC_CHAIN
) (
    input  logic                  Clk,
    input  logic                  rst,
    cascade_mod_counter_if.slave  bus
);

    // TC_VEC is left unsized so an over-wide terminal count shows up as a width error.
    if (WIDTH == 0 || NSTAGE == 0) begin : g_bad_shape
        $error("cascade_mod_counter: WIDTH and NSTAGE must be nonzero");
    end
    if ($bits(TC_VEC) != NSTAGE * WIDTH) begin : g_bad_tc_vec
        $error("cascade_mod_counter: TC_VEC must hold NSTAGE fields of WIDTH bits");
    end

    logic [NSTAGE-1:0] step;
    logic [NSTAGE-1:0] tc_w;
    logic [NSTAGE-1:0] ovr;
    logic              gate;
    logic [WIDTH-1:0]  field;
    logic [WIDTH-1:0]  tc_val;
    logic [WIDTH-1:0]  clamped [NSTAGE];
    logic [WIDTH-1:0]  stage_q [NSTAGE];

    logic carry_d;
    logic carry_q;
    logic load_err_d;
    logic load_err_q;

    // gate accumulates en & tc[0] & ... & tc[i-1]; tc comes from registers, so no loop.
    always_comb begin
        step = '0;
        gate = bus.en;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            step[i] = gate;
            gate    = gate & tc_w[i];
        end
    end

    always_comb begin
        ovr    = '0;
        field  = '0;
        tc_val = '0;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            clamped[i] = '0;
        end
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            field      = bus.load_data[i*WIDTH +: WIDTH];
            tc_val     = TC_VEC[i*WIDTH +: WIDTH];
            ovr[i]     = (field > tc_val);
            clamped[i] = ovr[i] ? tc_val : field;
        end
    end

    for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
        mod_counter_stage #(
            .WIDTH (WIDTH),
            .TC    (TC_VEC[g*WIDTH +: WIDTH])
        ) u_stage (
            .Clk   (Clk),
            .rst   (rst),
            .step  (step[g]),
            .up    (bus.up),
            .clr   (bus.clr),
            .load  (bus.load),
            .value (clamped[g]),
            .q     (stage_q[g]),
            .tc    (tc_w[g])
        );
    end

    always_comb begin
        carry_d    = bus.en & ~bus.clr & ~bus.load & (&tc_w);
        load_err_d = bus.load & ~bus.clr & (|ovr);
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    always_comb begin
        bus.q = '0;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            bus.q[i*WIDTH +: WIDTH] = stage_q[i];
        end
        bus.tc        = tc_w;
        bus.carry_out = carry_q;
        bus.load_err  = load_err_q;
    end

endmodule
